// File: rtl/serial_alu_sequencer_pkg.sv
// Shared opcodes, slice op codes and FSM states for the
// bit-serial ALU sequencer.
package serial_alu_sequencer_pkg;

  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_SUB  = 3'b001;
  localparam logic [2:0] OPC_AND  = 3'b010;
  localparam logic [2:0] OPC_OR   = 3'b011;
  localparam logic [2:0] OPC_NOR  = 3'b100;
  localparam logic [2:0] OPC_NAND = 3'b101;

  localparam logic [1:0] SOP_ADD  = 2'b00;
  localparam logic [1:0] SOP_AND  = 2'b01;
  localparam logic [1:0] SOP_OR   = 2'b10;
  localparam logic [1:0] SOP_ZERO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_alu_sequencer_decode.sv
// alu_seq_decode: opcode -> slice ainv/binv/op and arith flag.
// Ports: opc in; ainv, binv, op, arith out (combinational).
module alu_seq_decode
  import serial_alu_sequencer_pkg::*;
(
  input  logic [2:0] opc,
  output logic       ainv,
  output logic       binv,
  output logic [1:0] op,
  output logic       arith
);

  always_comb begin
    ainv  = 1'b0;
    binv  = 1'b0;
    op    = SOP_ZERO;
    arith = 1'b0;
    unique case (1'b1)
      (opc == OPC_ADD): begin
        op    = SOP_ADD;
        arith = 1'b1;
      end
      (opc == OPC_SUB): begin
        binv  = 1'b1;
        op    = SOP_ADD;
        arith = 1'b1;
      end
      (opc == OPC_AND): op = SOP_AND;
      (opc == OPC_OR):  op = SOP_OR;
      (opc == OPC_NOR): begin
        ainv = 1'b1;
        binv = 1'b1;
        op   = SOP_AND;
      end
      (opc == OPC_NAND): begin
        ainv = 1'b1;
        binv = 1'b1;
        op   = SOP_OR;
      end
      default: op = SOP_ZERO;
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial driver for an external 1-bit ALU slice, LSB first.
// Ports: cmd_* in, slice_* out/in, res_* out; ALU_SEQ_FLAGS_EN adds res_zero/res_ovf.
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opc,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_ainv,
  output logic             slice_binv,
  output logic             slice_cin,
  output logic [1:0]       slice_op,
  input  logic             slice_res,
  input  logic             slice_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             res_zero,
  output logic             res_ovf,
`endif
  output logic             res_carry
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [2:0]       opc_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry_q;

  logic       d_ainv, d_binv, d_arith;
  logic [1:0] d_op;

  alu_seq_decode u_dec (
    .opc   (opc_q),
    .ainv  (d_ainv),
    .binv  (d_binv),
    .op    (d_op),
    .arith (d_arith)
  );

  logic accept, run, done;
  assign accept = (state_q == IDLE) && cmd_valid;
  assign run    = (state_q == RUN);
  assign done   = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid) state_d = RUN;
      RUN:  if (cnt_q == LAST) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      opc_q   <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      opc_q   <= cmd_opc;
      a_sh    <= cmd_a;
      b_sh    <= cmd_b;
      res_sh  <= '0;
      carry_q <= (cmd_opc == OPC_SUB);
    end else if (run) begin
      cnt_q   <= cnt_q + CW'(1);
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= {slice_res, res_sh[WIDTH-1:1]};
      carry_q <= slice_cout;
    end
  end

  always_comb begin
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_ainv = 1'b0;
    slice_binv = 1'b0;
    slice_cin  = 1'b0;
    slice_op   = SOP_ZERO;
    if (run) begin
      slice_a    = a_sh[0];
      slice_b    = b_sh[0];
      slice_ainv = d_ainv;
      slice_binv = d_binv;
      slice_cin  = d_arith & carry_q;
      slice_op   = d_op;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = done;
  assign res_data  = res_sh;
  assign res_carry = done & d_arith & carry_q;

`ifdef ALU_SEQ_FLAGS_EN
  // Carry into the MSB is the carry reg value during the last RUN cycle.
  logic cmsb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmsb_q <= 1'b0;
    else if (run && cnt_q == LAST) cmsb_q <= carry_q;
  end

  assign res_zero = done & (res_sh == '0);
  assign res_ovf  = done & d_arith & (cmsb_q ^ carry_q);
`endif

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer with a behavioural
// 1-bit ALU slice; define ALU_SEQ_FLAGS_EN to check flags too.
module tb_serial_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_opc = 3'b000;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       slice_a, slice_b;
  logic       slice_ainv, slice_binv, slice_cin;
  logic [1:0] slice_op;
  logic       slice_res, slice_cout;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero, res_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic ma, mb;
  assign ma = slice_a ^ slice_ainv;
  assign mb = slice_b ^ slice_binv;
  assign slice_cout = (ma & mb) | (ma & slice_cin) | (mb & slice_cin);
  assign slice_res = (slice_op == 2'b00) ? (ma ^ mb ^ slice_cin) :
                     (slice_op == 2'b01) ? (ma & mb) :
                     (slice_op == 2'b10) ? (ma | mb) : 1'b0;

`ifndef ALU_SEQ_FLAGS_EN
  assign res_zero = 1'b0;
  assign res_ovf  = 1'b0;
`endif

  serial_alu_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opc    (cmd_opc),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_ainv (slice_ainv),
    .slice_binv (slice_binv),
    .slice_cin  (slice_cin),
    .slice_op   (slice_op),
    .slice_res  (slice_res),
    .slice_cout (slice_cout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
`ifdef ALU_SEQ_FLAGS_EN
    .res_zero   (res_zero),
    .res_ovf    (res_ovf),
`endif
    .res_carry  (res_carry)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string nm,
                       input logic [2:0] opc,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] ed,
                       input logic ec,
                       input logic ez,
                       input logic eo,
                       input int hold);
    int lat;
    @(negedge clk);
    check({nm, " rdy"}, 32'(cmd_ready), 32'd1);
    cmd_opc = opc;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 21;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = i;
        break;
      end
    end
    check({nm, " lat"}, 32'(lat), 32'd8);
    check({nm, " data"}, 32'(res_data), 32'(ed));
    check({nm, " carry"}, 32'(res_carry), 32'(ec));
`ifdef ALU_SEQ_FLAGS_EN
    check({nm, " zero"}, 32'(res_zero), 32'(ez));
    check({nm, " ovf"}, 32'(res_ovf), 32'(eo));
`else
    if (ez || eo) begin end
`endif
    if (hold > 0) begin
      cmd_opc = 3'b000;
      cmd_a = 8'h11;
      cmd_b = 8'h22;
      cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({nm, " hold data"}, 32'(res_data), 32'(ed));
        check({nm, " hold rdy"}, 32'(cmd_ready), 32'd0);
        check({nm, " hold vld"}, 32'(res_valid), 32'd1);
      end
      cmd_valid = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check({nm, " back idle"}, 32'(cmd_ready), 32'd1);
    check({nm, " vld clr"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #12;
    check("rst rdy", 32'(cmd_ready), 32'd1);
    check("rst vld", 32'(res_valid), 32'd0);
    check("rst data", 32'(res_data), 32'd0);
    check("rst carry", 32'(res_carry), 32'd0);
    check("rst sop", 32'(slice_op), 32'd3);
    check("rst sa", 32'({slice_a, slice_b, slice_ainv,
                         slice_binv, slice_cin}), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
    check("rst flags", 32'({res_zero, res_ovf}), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    do_op("add1", 3'b000, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 0);
    do_op("sub1", 3'b001, 8'h05, 8'h06, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    do_op("sub2", 3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 0);
    do_op("add2", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    do_op("add3", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 0);
    do_op("and",  3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 0);
    do_op("or",   3'b011, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 0);
    do_op("nor",  3'b100, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, 1'b0, 0);
    do_op("nand", 3'b101, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, 1'b0, 0);
    do_op("ill",  3'b110, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    do_op("hold", 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 5);

    @(negedge clk);
    cmd_opc = 3'b000;
    cmd_a = 8'hAA;
    cmd_b = 8'h55;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid run sop", 32'(slice_op), 32'd0);
    rst = 1'b1;
    #1;
    check("mrst rdy", 32'(cmd_ready), 32'd1);
    check("mrst vld", 32'(res_valid), 32'd0);
    check("mrst sop", 32'(slice_op), 32'd3);
    check("mrst data", 32'(res_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post", 3'b000, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
